// File: rtl/gamepad_reader.sv
// SNES-style pad poller: latch, shift NUM_BITS serial bits, publish 12 active-high buttons.
// Build option GAMEPAD_DEBOUNCE_EN: a button changes only after two consecutive agreeing frames.
module gamepad_reader #(
   parameter int unsigned CLK_DIV     = 150,
   parameter int unsigned NUM_BITS    = 16,
   parameter int unsigned POLL_CYCLES = 416667
) (
   input  logic clk,
   input  logic reset,
   input  logic pad_data,
   output logic pad_latch,
   output logic pad_clk,
   output logic B,
   output logic Y,
   output logic select,
   output logic start,
   output logic up,
   output logic down,
   output logic left,
   output logic right,
   output logic A,
   output logic X,
   output logic L,
   output logic R,
   output logic frame_valid
);
   localparam int unsigned NB = 12;
   localparam int unsigned DW = $clog2(2 * CLK_DIV);
   localparam int unsigned BW = $clog2(NUM_BITS);
   localparam int unsigned TW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;

   localparam logic [DW-1:0] HALF_LAST  = DW'(CLK_DIV - 1);
   localparam logic [DW-1:0] PER_LAST   = DW'(2 * CLK_DIV - 1);
   localparam logic [BW-1:0] BIT_LAST   = BW'(NUM_BITS - 1);
   localparam logic [BW-1:0] BIT_KEEP   = BW'(NB);
   localparam logic [TW-1:0] TIMER_LAST = TW'(POLL_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, LATCH, SHIFT, DONE} state_t;

   state_t          state;
   logic [DW-1:0]   div_cnt;
   logic [BW-1:0]   bit_cnt;
   logic [TW-1:0]   timer;
   logic [NB-1:0]   shreg;
   logic [NB-1:0]   btn;
   logic [NB-1:0]   raw;
`ifdef GAMEPAD_DEBOUNCE_EN
   logic [NB-1:0]   hist;
   logic [NB-1:0]   same;
   assign same = ~(raw ^ hist);
`endif

   assign raw = ~shreg;
   assign {R, L, X, A, right, left, down, up, start, select, Y, B} = btn;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         pad_latch   <= 1'b0;
         pad_clk     <= 1'b1;
         frame_valid <= 1'b0;
         div_cnt     <= '0;
         bit_cnt     <= '0;
         timer       <= TIMER_LAST;
         shreg       <= '0;
         btn         <= '0;
`ifdef GAMEPAD_DEBOUNCE_EN
         hist        <= '0;
`endif
      end else begin
         frame_valid <= 1'b0;
         // Timer saturates so a short poll period degrades to back-to-back frames.
         if (timer != TIMER_LAST) timer <= timer + TW'(1);
         unique case (state)
            IDLE, DONE: begin
               if (timer == TIMER_LAST) begin
                  state     <= LATCH;
                  pad_latch <= 1'b1;
                  div_cnt   <= '0;
                  timer     <= '0;
               end else begin
                  state <= IDLE;
               end
            end
            LATCH: begin
               if (div_cnt == PER_LAST) begin
                  state     <= SHIFT;
                  pad_latch <= 1'b0;
                  pad_clk   <= 1'b0;
                  div_cnt   <= '0;
                  bit_cnt   <= '0;
               end else begin
                  div_cnt <= div_cnt + DW'(1);
               end
            end
            SHIFT: begin
               // Sample on the last low cycle, just ahead of the rising pad_clk.
               if (div_cnt == HALF_LAST) begin
                  pad_clk <= 1'b1;
                  if (bit_cnt < BIT_KEEP) shreg <= {pad_data, shreg[NB-1:1]};
               end
               if (div_cnt == PER_LAST) begin
                  div_cnt <= '0;
                  if (bit_cnt == BIT_LAST) begin
                     state       <= DONE;
                     frame_valid <= 1'b1;
`ifdef GAMEPAD_DEBOUNCE_EN
                     btn  <= (raw & same) | (btn & ~same);
                     hist <= raw;
`else
                     btn  <= raw;
`endif
                  end else begin
                     bit_cnt <= bit_cnt + BW'(1);
                     pad_clk <= 1'b0;
                  end
               end else begin
                  div_cnt <= div_cnt + DW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
